// File: rtl/evt_pkg.sv
// Shared types and constants for the event stream transmitter.
// Holds the FSM state encoding and the drop-counter width/saturating increment.
package evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } evt_tx_state_e;

  localparam int unsigned DROP_CNT_W = 16;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] drop_cnt_inc(input logic [DROP_CNT_W-1:0] cnt);
    logic [DROP_CNT_W-1:0] res;
    if (cnt == {DROP_CNT_W{1'b1}}) begin
      res = cnt;
    end else begin
      res = cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/evt_stream_tx_if.sv
// Valid/ready event stream carrying one payload of type T per beat.
// src drives evt/valid and samples ready; dst is the mirror image.
interface SNE_EVENT_STREAM #(
  parameter type T = logic
);
  T     evt;
  logic valid;
  logic ready;

  modport src (output evt, output valid, input ready);
  modport dst (input evt, input valid, output ready);
endinterface

// File: rtl/evt_stream_tx_buf.sv
// Circular event buffer for evt_stream_tx: storage plus read/write pointers.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module evt_tx_buf #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         data_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  T            mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        push_ok_s;
  logic        pop_ok_s;

  // Qualify requests so the pointers can never overrun or underrun.
  always_comb begin
    push_ok_s = push_i & ~full_o & ~clr_i;
    pop_ok_s  = pop_i & ~empty_o & ~clr_i;
  end

  // Pointer update; a clear empties the buffer immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clr_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_r[rd_ptr_r[AW-1:0]];
  assign empty_o = (wr_ptr_r == rd_ptr_r);
  assign full_o  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count_o = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/evt_stream_tx.sv
// Event stream transmitter: buffers pushed events and launches them as
// valid/ready beats through a registered output stage.
// Optional feature: define EVT_STREAM_TX_DROP_CNT_EN to add drop_cnt_o, a
// saturating 16-bit count of pushes dropped while full or while flushing.
module evt_stream_tx
  import evt_pkg::*;
#(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       push_i,
  input  T                           evt_i,
  output logic                       full_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       idle_o,
`ifdef EVT_STREAM_TX_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
`endif
  SNE_EVENT_STREAM.src               evt_stream
);

  localparam int unsigned AW = $clog2(DEPTH);

  evt_tx_state_e state_r;
  logic          valid_r;
  T              evt_r;

  T              buf_data_s;
  logic          buf_full_s;
  logic          buf_empty_s;
  logic [AW:0]   buf_count_s;

  logic          hs_s;
  logic          slot_free_s;
  logic          accept_s;
  logic          launch_ok_s;
  logic          pop_s;
  logic          bypass_s;
  logic          buf_push_s;

  // Handshake and launch decisions. An event pushed into an empty buffer
  // while the output stage can load bypasses storage for 1-cycle latency.
  always_comb begin
    hs_s        = valid_r & evt_stream.ready;
    slot_free_s = ~valid_r | hs_s;
    accept_s    = push_i & ~buf_full_s & ~flush_i & (state_r != ST_FLUSH);
    launch_ok_s = enable_i & slot_free_s & ~flush_i & (state_r != ST_FLUSH);
    pop_s       = launch_ok_s & ~buf_empty_s;
    bypass_s    = launch_ok_s & buf_empty_s & accept_s;
    buf_push_s  = accept_s & ~bypass_s;
  end

  evt_tx_buf #(
    .T     (T),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (flush_i),
    .push_i  (buf_push_s),
    .pop_i   (pop_s),
    .data_i  (evt_i),
    .data_o  (buf_data_s),
    .full_o  (buf_full_s),
    .empty_o (buf_empty_s),
    .count_o (buf_count_s)
  );

  // Control FSM and registered output stage; an in-flight beat is only
  // retired by its handshake (or by reset), never by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      evt_r   <= '0;
    end else if (flush_i) begin
      state_r <= ST_FLUSH;
      if (hs_s) begin
        valid_r <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            evt_r   <= buf_data_s;
            valid_r <= 1'b1;
            state_r <= ST_SEND;
          end else if (bypass_s) begin
            evt_r   <= evt_i;
            valid_r <= 1'b1;
            state_r <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop_s) begin
            evt_r   <= buf_data_s;
            valid_r <= 1'b1;
          end else if (bypass_s) begin
            evt_r   <= evt_i;
            valid_r <= 1'b1;
          end else if (hs_s) begin
            valid_r <= 1'b0;
            if (buf_empty_s) begin
              state_r <= ST_IDLE;
            end
          end else if (!valid_r && buf_empty_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (!valid_r || hs_s) begin
            valid_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef EVT_STREAM_TX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  // Count pushes that were not accepted (buffer full, flush request, FLUSH state).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_r <= '0;
    end else if (push_i && !accept_s) begin
      drop_cnt_r <= drop_cnt_inc(drop_cnt_r);
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

  assign evt_stream.evt   = evt_r;
  assign evt_stream.valid = valid_r;
  assign full_o           = buf_full_s;
  assign occupancy_o      = buf_count_s;
  assign idle_o           = buf_empty_s & ~valid_r & (state_r == ST_IDLE);

endmodule

// File: tb/tb_evt_stream_tx.sv
// Directed self-checking bench for evt_stream_tx (DEPTH=8, 8-bit events).
module tb_evt_stream_tx;
  import evt_pkg::*;

  typedef logic [7:0] evt_t;
  localparam int unsigned DEPTH = 8;

  logic       clk_i;
  logic       rst_i;
  logic       enable_i;
  logic       push_i;
  evt_t       evt_i;
  logic       full_o;
  logic       flush_i;
  logic [3:0] occupancy_o;
  logic       idle_o;
`ifdef EVT_STREAM_TX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_o;
`endif

  int n_checks;
  int n_errors;
  int idx;

  SNE_EVENT_STREAM #(.T(evt_t)) evt_stream ();

  evt_stream_tx #(
    .T     (evt_t),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .push_i      (push_i),
    .evt_i       (evt_i),
    .full_o      (full_o),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o),
    .idle_o      (idle_o),
`ifdef EVT_STREAM_TX_DROP_CNT_EN
    .drop_cnt_o  (drop_cnt_o),
`endif
    .evt_stream  (evt_stream)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_i = 1'b1;
    enable_i = 1'b0;
    push_i = 1'b0;
    evt_i = 8'h00;
    flush_i = 1'b0;
    evt_stream.ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, evt_stream.valid}, 32'd0);
    chk("rst_evt", {24'd0, evt_stream.evt}, 32'd0);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_occ", {28'd0, occupancy_o}, 32'd0);
    chk("rst_idle", {31'd0, idle_o}, 32'd1);
    rst_i = 1'b0;
    tick();

    // Single push with 1-cycle latency.
    enable_i = 1'b1;
    evt_stream.ready = 1'b1;
    push_i = 1'b1;
    evt_i = 8'h05;
    tick();
    push_i = 1'b0;
    chk("lat_valid", {31'd0, evt_stream.valid}, 32'd1);
    chk("lat_evt", {24'd0, evt_stream.evt}, 32'h05);
    chk("lat_idle_busy", {31'd0, idle_o}, 32'd0);
    tick();
    chk("lat_valid_done", {31'd0, evt_stream.valid}, 32'd0);
    chk("lat_idle", {31'd0, idle_o}, 32'd1);

    // Fill with ready low: one beat launched, 8 buffered, 1 dropped.
    evt_stream.ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_i = 1'b1;
      evt_i = 8'h10 + 8'(i);
      tick();
    end
    push_i = 1'b0;
    chk("fill_full", {31'd0, full_o}, 32'd1);
    chk("fill_occ", {28'd0, occupancy_o}, 32'd8);
    chk("fill_valid", {31'd0, evt_stream.valid}, 32'd1);
    chk("fill_evt", {24'd0, evt_stream.evt}, 32'h10);
`ifdef EVT_STREAM_TX_DROP_CNT_EN
    chk("fill_drop", {16'd0, drop_cnt_o}, 32'd1);
`endif
    evt_stream.ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("drain_valid", {31'd0, evt_stream.valid}, 32'd1);
      chk("drain_evt", {24'd0, evt_stream.evt}, 32'h10 + k);
      tick();
      if (k == 0) chk("drain_not_full", {31'd0, full_o}, 32'd0);
    end
    chk("drain_valid_end", {31'd0, evt_stream.valid}, 32'd0);
    chk("drain_idle", {31'd0, idle_o}, 32'd1);

    // Four-event burst with ready toggling: no change while stalled, order kept.
    evt_stream.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_i = 1'b1;
      evt_i = 8'h20 + 8'(i);
      tick();
    end
    push_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      evt_stream.ready = c[0];
      if (evt_stream.valid) chk("burst_evt", {24'd0, evt_stream.evt}, 32'h20 + idx);
      if (evt_stream.valid && evt_stream.ready) idx++;
      tick();
    end
    chk("burst_count", idx, 32'd4);
    chk("burst_valid_end", {31'd0, evt_stream.valid}, 32'd0);
    evt_stream.ready = 1'b0;

    // Flush with 0xA in flight and 5 buffered.
    push_i = 1'b1;
    evt_i = 8'h0A;
    tick();
    for (int i = 0; i < 5; i++) begin
      evt_i = 8'h31 + 8'(i);
      tick();
    end
    push_i = 1'b0;
    chk("pre_flush_occ", {28'd0, occupancy_o}, 32'd5);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_occ", {28'd0, occupancy_o}, 32'd0);
    chk("flush_valid", {31'd0, evt_stream.valid}, 32'd1);
    chk("flush_evt", {24'd0, evt_stream.evt}, 32'h0A);
    chk("flush_idle_busy", {31'd0, idle_o}, 32'd0);
    push_i = 1'b1;
    evt_i = 8'h77;
    tick();
    push_i = 1'b0;
    chk("flush_push_ign", {28'd0, occupancy_o}, 32'd0);
    chk("flush_hold_evt", {24'd0, evt_stream.evt}, 32'h0A);
`ifdef EVT_STREAM_TX_DROP_CNT_EN
    chk("flush_drop", {16'd0, drop_cnt_o}, 32'd2);
`endif
    evt_stream.ready = 1'b1;
    tick();
    chk("flush_valid_done", {31'd0, evt_stream.valid}, 32'd0);
    chk("flush_idle", {31'd0, idle_o}, 32'd1);

    // enable low holds buffered events; raising it gives back-to-back beats.
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_i = 1'b1;
      evt_i = 8'h41 + 8'(i);
      tick();
    end
    push_i = 1'b0;
    chk("en_occ", {28'd0, occupancy_o}, 32'd3);
    chk("en_valid_low", {31'd0, evt_stream.valid}, 32'd0);
    tick();
    chk("en_valid_low2", {31'd0, evt_stream.valid}, 32'd0);
    enable_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_b2b_valid", {31'd0, evt_stream.valid}, 32'd1);
      chk("en_b2b_evt", {24'd0, evt_stream.evt}, 32'h41 + k);
    end
    tick();
    chk("en_valid_end", {31'd0, evt_stream.valid}, 32'd0);
    chk("en_idle", {31'd0, idle_o}, 32'd1);

    // Asynchronous reset in the middle of a stalled beat.
    evt_stream.ready = 1'b0;
    push_i = 1'b1;
    evt_i = 8'h55;
    tick();
    evt_i = 8'h56;
    tick();
    push_i = 1'b0;
    chk("mid_valid", {31'd0, evt_stream.valid}, 32'd1);
    chk("mid_occ", {28'd0, occupancy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("arst_valid", {31'd0, evt_stream.valid}, 32'd0);
    chk("arst_occ", {28'd0, occupancy_o}, 32'd0);
    chk("arst_evt", {24'd0, evt_stream.evt}, 32'd0);
    chk("arst_idle", {31'd0, idle_o}, 32'd1);
`ifdef EVT_STREAM_TX_DROP_CNT_EN
    chk("arst_drop", {16'd0, drop_cnt_o}, 32'd0);
`endif
    tick();
    rst_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/evt_stream_tx.md
EVT_STREAM_TX -- requirements
Module: evt_stream_tx

Interface
REQ-001 SHALL have parameter T, default logic: event payload type.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port enable_i, input, 1 bit: when high, new beats may launch on the stream.
REQ-006 SHALL have port push_i, input, 1 bit: write request for evt_i.
REQ-007 SHALL have port evt_i, input, T: event to transmit.
REQ-008 SHALL have port full_o, output, 1 bit: buffer holds DEPTH entries.
REQ-009 SHALL have port flush_i, input, 1 bit: discard all buffered, not-yet-launched events.
REQ-010 SHALL have port occupancy_o, output, $clog2(DEPTH)+1 bits: buffered entries, excluding the launched beat.
REQ-011 SHALL have port idle_o, output, 1 bit: buffer empty, no beat valid, FSM in IDLE.
REQ-012 SHALL have port evt_stream, SNE_EVENT_STREAM.src, driving evt and valid and sampling ready.

Function
REQ-013 SHALL implement a single-clock circular buffer with write and read pointers one bit wider than log2(DEPTH); full when the MSBs differ and the rest match.
REQ-014 SHALL accept push_i only when full_o is low; a push while full is dropped, even when a pop occurs in the same cycle.
REQ-015 SHALL register evt_stream.valid and evt_stream.evt in an output stage; a push into an empty buffer with enable_i high gives valid in the next cycle (1-cycle latency).
REQ-016 SHALL hold evt_stream.evt and valid stable while valid is high and ready is low; valid SHALL never drop before the handshake.
REQ-017 SHALL reload the output stage on a handshake in the same cycle when the buffer is non-empty and enable_i is high, sustaining 1 beat per cycle.
REQ-018 SHALL use an FSM with states IDLE, SEND and FLUSH. IDLE goes to SEND on a non-empty buffer with enable_i high. SEND goes to IDLE when the buffer is empty at handshake.
REQ-019 SHALL enter FLUSH from any state on flush_i. FLUSH clears the pointers at once and keeps any in-flight beat until its handshake, then goes to IDLE. Pushes are ignored in FLUSH.
REQ-020 SHALL, when enable_i is low, launch no new beat and complete any in-flight beat normally.
REQ-021 SHALL give flush_i priority over push_i in the same cycle.

Reset
REQ-022 SHALL, on rst_i high, asynchronously clear the pointers and FSM (IDLE) and drive evt_stream.valid=0, evt_stream.evt='0, full_o=0, occupancy_o=0, idle_o=1.
REQ-023 SHALL drop an in-flight beat on reset mid-transfer; valid SHALL fall in the reset cycle.

Configuration
REQ-024 SHALL, with macro EVT_STREAM_TX_DROP_CNT_EN defined, add output drop_cnt_o (16 bits), which counts dropped pushes (REQ-014, REQ-019), saturates at 0xFFFF and is cleared by reset.
REQ-025 SHALL, without EVT_STREAM_TX_DROP_CNT_EN, have no drop_cnt_o port and no counter logic.

Structure
REQ-026 SHALL place the FSM state enum (evt_tx_state_e) and the drop-counter width constant in the shared package evt_pkg.
REQ-027 SHALL implement the buffer as sub-module evt_tx_buf (storage plus pointers); the FSM and output stage stay in evt_stream_tx.

Verification
REQ-028 Reset, then push 0x5 at cycle 0 with enable=1 and ready=1 -> valid=1, evt=0x5 at cycle 1; idle_o=1 at cycle 2.
REQ-029 Push 10 events with ready=0 (DEPTH=8) -> full_o=1 after 8 entries, occupancy_o=8 (excluding launched beat), drop_cnt_o=1 (macro on); release ready -> 9 beats out in order.
REQ-030 Ready toggles 1/0 each cycle during a 4-event burst -> evt never changes while valid&&!ready; order 0..3 preserved.
REQ-031 Buffer holds 5 with beat 0xA in flight and ready=0; assert flush_i -> occupancy_o=0 next cycle; 0xA held until ready, then idle_o=1.
REQ-032 enable_i=0 with 3 buffered -> valid stays 0; enable_i=1 -> first valid next cycle, 3 back-to-back beats with ready=1.
REQ-033 Assert rst_i mid-beat (valid=1, ready=0) -> valid=0 and occupancy_o=0 immediately, no clock edge needed.
